// File: rtl/ir_pkg.sv
// Shared constants for the instruction-register prefetch queue and its
// decode consumers: default geometry and the LC-3 opcode field position.
package ir_pkg;

   // Default instruction word width and prefetch queue depth.
   localparam int IR_WIDTH_DEF = 16;
   localparam int IR_DEPTH_DEF = 4;

   // LC-3 opcode field position inside an instruction word.
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;

   // Extract the opcode field from an LC-3 instruction word.
   function automatic logic [OPC_MSB-OPC_LSB:0] ir_opcode(input logic [IR_WIDTH_DEF-1:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage : ir_pkg

// File: rtl/ir_fifo_mem.sv
// Prefetch queue storage: DEPTH x WIDTH register array with one synchronous
// write port and one asynchronous read port addressed by the read pointer.
module ir_fifo_mem
   import ir_pkg::*;
#(
   parameter int WIDTH = IR_WIDTH_DEF,
   parameter int DEPTH = IR_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage array: cleared on reset so the read port never presents X.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end else begin
         mem_q[waddr_i] <= mem_q[waddr_i];
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ir_fifo_mem

// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch queue in front of it.
// Words arrive from the bus on ldIR; the control FSM consumes IR on advIR.
// IR refills automatically whenever it is invalid. flush discards queued
// words and IR; overflow is a sticky flag for pushes dropped at full.
module ir_queue
   import ir_pkg::*;
#(
   parameter int               WIDTH    = IR_WIDTH_DEF,
   parameter int               DEPTH    = IR_DEPTH_DEF,
   parameter int               BYPASS   = 1,
   parameter logic [WIDTH-1:0] IR_RESET = {WIDTH{1'b0}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ldIR,
   input  logic [WIDTH-1:0]           Buss,
   input  logic                       advIR,
   input  logic                       flush,
   output logic [WIDTH-1:0]           IR,
   output logic                       irValid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int             PW       = $clog2(DEPTH);
   localparam int             CW       = $clog2(DEPTH+1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [PW-1:0]  PTR_ZERO = PW'(0);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
   localparam logic           BYP_EN   = (BYPASS != 0);

   // Architectural state and its next-state values.
   logic [PW-1:0]    wptr_q,  wptr_d;
   logic [PW-1:0]    rptr_q,  rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] ir_q,    ir_d;
   logic             valid_q, valid_d;
   logic             full_q,  full_d;
   logic             empty_q, empty_d;
   logic             ovf_q,   ovf_d;

   // Per-edge events.
   logic             pop_req_s;
   logic             q_nonempty_s;
   logic             pop_q_s;
   logic             bypass_s;
   logic             push_try_s;
   logic             push_acc_s;
   logic             drop_s;
   logic             mem_we_s;
   logic [WIDTH-1:0] rdata_s;

   // IR wants a new word when it is being consumed or holds nothing.
   assign pop_req_s    = advIR | ~valid_q;
   assign q_nonempty_s = (count_q != CNT_ZERO);
   assign pop_q_s      = pop_req_s & q_nonempty_s;
   // A word arriving into an empty queue while IR wants a refill skips the queue.
   assign bypass_s     = BYP_EN & pop_req_s & ~q_nonempty_s & ldIR;
   assign push_try_s   = ldIR & ~bypass_s;
   // A pop on the same edge frees the slot, so a push at full still fits.
   assign push_acc_s   = push_try_s & ((count_q != DEPTH_C) | pop_q_s);
   assign drop_s       = push_try_s & ~push_acc_s;

   ir_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we_i    (mem_we_s),
      .waddr_i (wptr_q),
      .wdata_i (Buss),
      .raddr_i (rptr_q),
      .rdata_o (rdata_s)
   );

   // Next-state logic: flush wins over refill, push and overflow detection.
   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      ir_d     = ir_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      mem_we_s = 1'b0;
      if (flush) begin
         wptr_d  = PTR_ZERO;
         rptr_d  = PTR_ZERO;
         count_d = CNT_ZERO;
         ir_d    = IR_RESET;
         valid_d = 1'b0;
         ovf_d   = ovf_q;
      end else begin
         mem_we_s = push_acc_s;
         if (push_acc_s) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_q_s) begin
            ir_d    = rdata_s;
            valid_d = 1'b1;
            rptr_d  = rptr_q + PTR_ONE;
         end else if (bypass_s) begin
            ir_d    = Buss;
            valid_d = 1'b1;
         end else if (pop_req_s) begin
            valid_d = 1'b0;
         end else begin
            valid_d = valid_q;
         end
         if (drop_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
         case ({push_acc_s, pop_q_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == CNT_ZERO);
   end

   // State register: asynchronous clear to the idle, empty condition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= PTR_ZERO;
         rptr_q  <= PTR_ZERO;
         count_q <= CNT_ZERO;
         ir_q    <= IR_RESET;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ir_q    <= ir_d;
         valid_q <= valid_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
      end
   end

   assign IR       = ir_q;
   assign irValid  = valid_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = ovf_q;

endmodule : ir_queue
